// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX multicycle control unit: state encoding,
// instruction field constants, datapath select encodings and strobe decode.
package dlx_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ALU    = 4'd3,
        S_ALUI   = 4'd4,
        S_SHIFT  = 4'd5,
        S_ADDR   = 4'd6,
        S_LOAD   = 4'd7,
        S_STORE  = 4'd8,
        S_WBR    = 4'd9,
        S_WBI    = 4'd10,
        S_BRANCH = 4'd11,
        S_BTAKEN = 4'd12,
        S_JR     = 4'd13,
        S_JALR   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_JR      = 6'h12;
    localparam logic [5:0] OP_JALR    = 6'h13;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [1:0] S1_A   = 2'b00;
    localparam logic [1:0] S1_PC  = 2'b01;
    localparam logic [1:0] S1_MDR = 2'b10;

    localparam logic [1:0] S2_B   = 2'b00;
    localparam logic [1:0] S2_IMM = 2'b01;
    localparam logic [1:0] S2_ONE = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SRL  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] DEST_RT  = 2'b00;
    localparam logic [1:0] DEST_RD  = 2'b01;
    localparam logic [1:0] DEST_R31 = 2'b10;

    localparam logic [1:0] DINT_C   = 2'b00;
    localparam logic [1:0] DINT_MDR = 2'b01;
    localparam logic [1:0] DINT_PC  = 2'b10;

    typedef struct packed {
        logic       ir_ce;
        logic       pc_ce;
        logic       a_ce;
        logic       b_ce;
        logic       c_ce;
        logic       mdr_ce;
        logic       mr;
        logic       mw;
        logic       gpr_we;
        logic [1:0] s1sel;
        logic [1:0] s2sel;
        logic [2:0] alu_f;
        logic [1:0] dest_sel;
        logic [1:0] dint_sel;
    } ctrl_t;

    // Moore output decode; rtype_f is the func-derived ALU op, from_load marks a WBI entered from LOAD.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [2:0] rtype_f,
                                       input logic from_load);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mr    = 1'b1;
                c.ir_ce = 1'b1;
            end
            S_DECODE: begin
                c.a_ce  = 1'b1;
                c.b_ce  = 1'b1;
                c.pc_ce = 1'b1;
                c.s1sel = S1_PC;
                c.s2sel = S2_ONE;
                c.alu_f = ALU_ADD;
            end
            S_ALU, S_SHIFT: begin
                c.c_ce  = 1'b1;
                c.s1sel = S1_A;
                c.s2sel = S2_B;
                c.alu_f = rtype_f;
            end
            S_ALUI, S_ADDR: begin
                c.c_ce  = 1'b1;
                c.s1sel = S1_A;
                c.s2sel = S2_IMM;
                c.alu_f = ALU_ADD;
            end
            S_LOAD: begin
                c.mr     = 1'b1;
                c.mdr_ce = 1'b1;
            end
            S_STORE: c.mw = 1'b1;
            S_WBR: begin
                c.gpr_we   = 1'b1;
                c.dest_sel = DEST_RD;
                c.dint_sel = DINT_C;
            end
            S_WBI: begin
                c.gpr_we   = 1'b1;
                c.dest_sel = DEST_RT;
                c.dint_sel = from_load ? DINT_MDR : DINT_C;
            end
            S_BTAKEN: begin
                c.pc_ce = 1'b1;
                c.s1sel = S1_PC;
                c.s2sel = S2_IMM;
                c.alu_f = ALU_ADD;
            end
            S_JR: begin
                c.pc_ce = 1'b1;
                c.s1sel = S1_A;
                c.alu_f = ALU_PASS;
            end
            S_JALR: begin
                c.pc_ce    = 1'b1;
                c.s1sel    = S1_A;
                c.alu_f    = ALU_PASS;
                c.gpr_we   = 1'b1;
                c.dest_sel = DEST_R31;
                c.dint_sel = DINT_PC;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dlx_ctrl_decode.sv
// Instruction decode: maps opcode/func to the state following DECODE and the
// ALU function used by R-type execute states.
module dlx_ctrl_decode
    import dlx_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] func,
    output state_t         next_state,
    output logic [2:0]     alu_f
);

    always_comb begin
        next_state = S_HALT;
        alu_f      = ALU_ADD;
        case (opcode)
            OPW'(OP_SPECIAL): begin
                case (func)
                    OPW'(FN_ADD): begin next_state = S_ALU;   alu_f = ALU_ADD; end
                    OPW'(FN_SUB): begin next_state = S_ALU;   alu_f = ALU_SUB; end
                    OPW'(FN_AND): begin next_state = S_ALU;   alu_f = ALU_AND; end
                    OPW'(FN_OR):  begin next_state = S_ALU;   alu_f = ALU_OR;  end
                    OPW'(FN_XOR): begin next_state = S_ALU;   alu_f = ALU_XOR; end
                    OPW'(FN_SLL): begin next_state = S_SHIFT; alu_f = ALU_SLL; end
                    OPW'(FN_SRL): begin next_state = S_SHIFT; alu_f = ALU_SRL; end
                    default:      next_state = S_HALT;
                endcase
            end
            OPW'(OP_ADDI):            next_state = S_ALUI;
            OPW'(OP_LW), OPW'(OP_SW): next_state = S_ADDR;
            OPW'(OP_BEQZ),
            OPW'(OP_BNEZ):            next_state = S_BRANCH;
            OPW'(OP_JR):              next_state = S_JR;
            OPW'(OP_JALR):            next_state = S_JALR;
            default:                  next_state = S_HALT;
        endcase
    end

endmodule

// File: rtl/dlx_control.sv
// Multicycle DLX control FSM: sequences fetch/decode/execute/writeback and
// drives the datapath strobes and operand selects from registered state.
module dlx_control
    import dlx_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] func,
    input  logic           a_zero,
    input  logic           busy,
    output logic           ir_ce,
    output logic           pc_ce,
    output logic           a_ce,
    output logic           b_ce,
    output logic           c_ce,
    output logic           mdr_ce,
    output logic           mr,
    output logic           mw,
    output logic           gpr_we,
    output logic [1:0]     s1sel,
    output logic [1:0]     s2sel,
    output logic [2:0]     alu_f,
    output logic [1:0]     dest_sel,
    output logic [1:0]     dint_sel,
    output logic [3:0]     state
);

    state_t     cur;
    state_t     nxt;
    state_t     dec_next;
    logic [2:0] dec_alu_f;
    ctrl_t      ctrl;
    logic       started;
    logic       branch_taken;

    dlx_ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode     (opcode),
        .func       (func),
        .next_state (dec_next),
        .alu_f      (dec_alu_f)
    );

    assign branch_taken = ((opcode == OPW'(OP_BEQZ)) &&  a_zero) ||
                          ((opcode == OPW'(OP_BNEZ)) && !a_zero);

    always_comb begin
        nxt = cur;
        case (cur)
            S_INIT:   nxt = started ? S_FETCH : S_INIT;
            S_FETCH:  nxt = busy ? S_FETCH : S_DECODE;
            S_DECODE: nxt = dec_next;
            S_ALU, S_SHIFT: nxt = S_WBR;
            S_ALUI:   nxt = S_WBI;
            S_ADDR: begin
                if (opcode == OPW'(OP_LW))
                    nxt = S_LOAD;
                else if (opcode == OPW'(OP_SW))
                    nxt = S_STORE;
                else
                    nxt = S_HALT;
            end
            S_LOAD:   nxt = busy ? S_LOAD : S_WBI;
            S_STORE:  nxt = busy ? S_STORE : S_FETCH;
            S_BRANCH: nxt = branch_taken ? S_BTAKEN : S_FETCH;
            S_WBR, S_WBI, S_BTAKEN, S_JR, S_JALR: nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_HALT;
        endcase
    end

    // 'started' holds INIT for one edge after reset release so FETCH begins on the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_INIT;
            ctrl    <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            cur     <= nxt;
            ctrl    <= ctrl_for(nxt, dec_alu_f, cur == S_LOAD);
        end
    end

    assign ir_ce    = ctrl.ir_ce & ~busy;
    assign mdr_ce   = ctrl.mdr_ce & ~busy;
    assign pc_ce    = ctrl.pc_ce;
    assign a_ce     = ctrl.a_ce;
    assign b_ce     = ctrl.b_ce;
    assign c_ce     = ctrl.c_ce;
    assign mr       = ctrl.mr;
    assign mw       = ctrl.mw;
    assign gpr_we   = ctrl.gpr_we;
    assign s1sel    = ctrl.s1sel;
    assign s2sel    = ctrl.s2sel;
    assign alu_f    = ctrl.alu_f;
    assign dest_sel = ctrl.dest_sel;
    assign dint_sel = ctrl.dint_sel;
    assign state    = cur;

endmodule
